// File: rtl/imem_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// One request may be outstanding; addr is held until rvalid arrives.
interface imem_if;
  logic        req;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps one request in flight, loads the IF/ID slot,
// absorbs decode stalls with a one-entry skid buffer and squashes on redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic          clk,
  input  logic          rst,
  imem_if.master        imem,
  input  logic          branch_taken,
  input  logic [31:0]   branch_target,
  input  logic          stall,
  output logic          if_id_valid,
  output logic [31:0]   if_id_pc,
  output logic [31:0]   if_id_inst
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    KILL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic [XLEN-1:0]   kill_addr_q, kill_addr_d;
  logic [XLEN-1:0]   skid_inst_q, skid_inst_d;
  logic [XLEN-1:0]   skid_pc_q, skid_pc_d;
  logic              fresh_q, fresh_d;
  logic              if_id_valid_q, if_id_valid_d;
  logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
  logic [XLEN-1:0]   if_id_inst_q, if_id_inst_d;

  logic              rsp;
  logic              slot_free;
  logic [XLEN-1:0]   br_pc;

  // A killed request keeps presenting its original address until it retires.
  assign imem.req  = !rst && (state_q != HOLD);
  assign imem.addr = (state_q == KILL) ? kill_addr_q : pc_q;

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_inst  = if_id_inst_q;

  // Next-state and datapath selection
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    target_d      = target_q;
    kill_addr_d   = kill_addr_q;
    skid_inst_d   = skid_inst_q;
    skid_pc_d     = skid_pc_q;
    fresh_d       = 1'b0;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;

    // A strobe in the first cycle after reset belongs to an abandoned request.
    rsp       = imem.rvalid && !fresh_q;
    slot_free = !if_id_valid_q || !stall;
    br_pc     = {branch_target[XLEN-1:2], 2'b00};

    if (!stall) begin
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP_INST;
    end

    if (branch_taken) begin
      if_id_valid_d = 1'b0;
      if_id_inst_d  = NOP_INST;
      pc_d          = br_pc;
      target_d      = br_pc;
      case (state_q)
        FETCH: begin
          if (!rsp) begin
            state_d     = KILL;
            kill_addr_d = pc_q;
          end
        end
        HOLD:    state_d = FETCH;
        KILL:    if (imem.rvalid) state_d = FETCH;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (rsp) begin
            if (slot_free) begin
              if_id_valid_d = 1'b1;
              if_id_pc_d    = pc_q;
              if_id_inst_d  = imem.rdata;
              pc_d          = pc_q + XLEN'(4);
            end else begin
              skid_inst_d = imem.rdata;
              skid_pc_d   = pc_q;
              state_d     = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = skid_pc_q;
            if_id_inst_d  = skid_inst_q;
            pc_d          = pc_q + XLEN'(4);
            state_d       = FETCH;
          end
        end
        KILL: begin
          if (imem.rvalid) begin
            state_d = FETCH;
            pc_d    = target_q;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      target_q      <= '0;
      kill_addr_q   <= '0;
      skid_inst_q   <= '0;
      skid_pc_q     <= '0;
      fresh_q       <= 1'b1;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_inst_q  <= NOP_INST;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      target_q      <= target_d;
      kill_addr_q   <= kill_addr_d;
      skid_inst_q   <= skid_inst_d;
      skid_pc_q     <= skid_pc_d;
      fresh_q       <= fresh_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle-by-cycle vector table plus short
// sequences driven by a small variable-latency memory model.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;
  localparam int NV = 26;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;

  always #5 clk = ~clk;

  imem_if imem_bus ();

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk           (clk),
    .rst           (rst),
    .imem          (imem_bus.master),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .stall         (stall),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_inst    (if_id_inst)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] tgt;
    logic        st;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_v;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vecs [NV];

  int checks   = 0;
  int failures = 0;
  bit mem_en   = 1'b0;
  int mem_lat  = 1;
  int mem_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model answers with rdata = addr after mem_lat cycles of request.
  task automatic cyc();
    #1;
    if (mem_en) begin
      imem_bus.rvalid = imem_bus.req && (mem_cnt + 1 >= mem_lat);
      imem_bus.rdata  = imem_bus.addr;
      if (imem_bus.rvalid) mem_cnt = 0;
      else if (imem_bus.req) mem_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1; branch_taken = 1'b0; branch_target = '0; stall = 1'b0;
    imem_bus.rvalid = 1'b0; imem_bus.rdata = '0; mem_cnt = 0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'(v));
    if (v) begin
      chk({tag, "_pc"}, if_id_pc, pc);
      chk({tag, "_inst"}, if_id_inst, inst);
    end
  endtask

  initial begin
    //          rst   rv    rdata         br    tgt           st    e_req e_addr        e_v   e_pc          e_inst
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        NOP};
    vecs[1]  = '{1'b1, 1'b1, BAD,          1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        NOP};
    vecs[2]  = '{1'b0, 1'b1, BAD,          1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        NOP};
    vecs[3]  = '{1'b0, 1'b1, 32'hA000_0000, 1'b0, 32'h0,       1'b0, 1'b1, 32'h4,        1'b1, 32'h0,        32'hA000_0000};
    vecs[4]  = '{1'b0, 1'b1, 32'hA000_0001, 1'b0, 32'h0,       1'b0, 1'b1, 32'h8,        1'b1, 32'h4,        32'hA000_0001};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h8,        1'b0, 32'h4,        NOP};
    vecs[6]  = '{1'b0, 1'b1, 32'hA000_0002, 1'b0, 32'h0,       1'b0, 1'b1, 32'hC,        1'b1, 32'h8,        32'hA000_0002};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b1, 32'hC,        1'b1, 32'h8,        32'hA000_0002};
    vecs[8]  = '{1'b0, 1'b1, 32'hA000_0003, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'hA000_0002};
    vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'hA000_0002};
    vecs[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h10,       1'b1, 32'hC,        32'hA000_0003};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h102,      1'b0, 1'b1, 32'h10,       1'b0, 32'hC,        NOP};
    vecs[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h10,       1'b0, 32'hC,        NOP};
    vecs[13] = '{1'b0, 1'b1, BAD,          1'b0, 32'h0,        1'b0, 1'b1, 32'h100,      1'b0, 32'hC,        NOP};
    vecs[14] = '{1'b0, 1'b1, 32'hB000_0000, 1'b0, 32'h0,       1'b0, 1'b1, 32'h104,      1'b1, 32'h100,      32'hB000_0000};
    vecs[15] = '{1'b0, 1'b1, BAD,          1'b1, 32'h200,      1'b1, 1'b1, 32'h200,      1'b0, 32'h100,      NOP};
    vecs[16] = '{1'b0, 1'b1, 32'hC000_0000, 1'b0, 32'h0,       1'b1, 1'b1, 32'h204,      1'b1, 32'h200,      32'hC000_0000};
    vecs[17] = '{1'b0, 1'b1, 32'hC000_0001, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,        1'b1, 32'h200,      32'hC000_0000};
    vecs[18] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h303,      1'b1, 1'b1, 32'h300,      1'b0, 32'h200,      NOP};
    vecs[19] = '{1'b0, 1'b1, 32'hD000_0000, 1'b0, 32'h0,       1'b0, 1'b1, 32'h304,      1'b1, 32'h300,      32'hD000_0000};
    vecs[20] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h304,     1'b0, 32'h300,      NOP};
    vecs[21] = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h4,        1'b0, 1'b1, 32'h304,      1'b0, 32'h300,      NOP};
    vecs[22] = '{1'b0, 1'b1, BAD,          1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h300,    NOP};
    vecs[23] = '{1'b0, 1'b1, 32'hE000_0000, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0,        1'b1, 32'hFFFF_FFFC, 32'hE000_0000};
    vecs[24] = '{1'b0, 1'b1, 32'hE000_0001, 1'b0, 32'h0,       1'b0, 1'b1, 32'h4,        1'b1, 32'h0,        32'hE000_0001};
    vecs[25] = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        NOP};

    // Vector table, bus driven directly
    mem_en = 1'b0;
    for (int i = 0; i < NV; i++) begin
      rst             = vecs[i].rst;
      imem_bus.rvalid = vecs[i].rv;
      imem_bus.rdata  = vecs[i].rdata;
      branch_taken    = vecs[i].br;
      branch_target   = vecs[i].tgt;
      stall           = vecs[i].st;
      cyc();
      chk($sformatf("v%0d_req", i), 32'(imem_bus.req), 32'(vecs[i].e_req));
      if (vecs[i].e_req) chk($sformatf("v%0d_addr", i), imem_bus.addr, vecs[i].e_addr);
      chk($sformatf("v%0d_valid", i), 32'(if_id_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d_pc", i), if_id_pc, vecs[i].e_pc);
      chk($sformatf("v%0d_inst", i), if_id_inst, vecs[i].e_inst);
    end

    // Zero-wait memory: back-to-back loads 0,4,8,12
    mem_en = 1'b1; mem_lat = 1;
    reset_dut();
    cyc();
    chk("zw_first_ignored", 32'(if_id_valid), 32'(1'b0));
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk_slot($sformatf("zw%0d", k), 1'b1, 32'(4 * k), 32'(4 * k));
    end

    // Two-cycle latency: address held 2 cycles, one valid pulse per fetch
    mem_lat = 2;
    reset_dut();
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("l2_addr%0d", k), imem_bus.addr, 32'(4 * (k / 2)));
      chk_slot($sformatf("l2_%0d", k), 1'(k % 2 == 0), 32'(4 * (k / 2 - 1)), 32'(4 * (k / 2 - 1)));
    end

    // Three-cycle stall with a response arriving: skid then release
    mem_lat = 1;
    reset_dut();
    cyc();
    cyc();
    chk_slot("st_pre", 1'b1, 32'h0, 32'h0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("st_req%0d", k), 32'(imem_bus.req), 32'(1'b0));
      chk_slot($sformatf("st_hold%0d", k), 1'b1, 32'h0, 32'h0);
    end
    stall = 1'b0;
    cyc();
    chk_slot("st_skid", 1'b1, 32'h4, 32'h4);
    cyc();
    chk_slot("st_next", 1'b1, 32'h8, 32'h8);

    // Reset while in KILL, stale strobe right after reset
    mem_en = 1'b0;
    reset_dut();
    cyc();
    cyc();
    branch_taken = 1'b1; branch_target = 32'h80;
    cyc();
    branch_taken = 1'b0;
    chk("rk_kill_addr", imem_bus.addr, 32'h0);
    chk("rk_kill_req", 32'(imem_bus.req), 32'(1'b1));
    rst = 1'b1;
    cyc();
    chk("rk_req_in_rst", 32'(imem_bus.req), 32'(1'b0));
    rst = 1'b0; imem_bus.rvalid = 1'b1; imem_bus.rdata = BAD;
    #1;
    chk("rk_req_after_rst", 32'(imem_bus.req), 32'(1'b1));
    cyc();
    chk("rk_stale_ignored", 32'(if_id_valid), 32'(1'b0));
    imem_bus.rdata = 32'h0000_0011;
    cyc();
    chk_slot("rk_first", 1'b1, 32'h0, 32'h0000_0011);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with no other clock or asynchronous input.
REQ-002 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0): value of if_id_inst when the slot is empty.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst  in  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-006 imem_req  out  1  instruction-memory request, held high until the response arrives.
REQ-007 imem_addr  out  32  word-aligned fetch address, stable while imem_req=1.
REQ-008 imem_rvalid  in  1  response strobe: imem_rdata is valid in this cycle.
REQ-009 imem_rdata  in  32  fetched instruction word.
REQ-010 branch_taken  in  1  redirect from the execute stage (Branch AND zero).
REQ-011 branch_target  in  32  redirect address.
REQ-012 stall  in  1  hazard hold: the decode stage does not consume the IF/ID slot.
REQ-013 if_id_valid  out  1  the IF/ID slot holds a live instruction.
REQ-014 if_id_pc  out  32  PC of the instruction in the IF/ID slot.
REQ-015 if_id_inst  out  32  instruction in the IF/ID slot; bits [6:2] drive the opcode decoder.

Function
REQ-016 The block SHALL keep one outstanding request at most and SHALL NOT change imem_addr while imem_req=1 and imem_rvalid=0.
REQ-017 The FSM SHALL have exactly three states: FETCH, HOLD and KILL.
REQ-018 FETCH: imem_req=1 and imem_addr=pc.
- imem_rvalid=1, branch_taken=0, slot free (if_id_valid=0 or stall=0): load if_id_inst=imem_rdata, if_id_pc=pc and if_id_valid=1; pc <= pc+4; stay in FETCH.
- imem_rvalid=1, branch_taken=0, slot occupied and stall=1: capture rdata/pc into a one-entry skid buffer; go to HOLD.
REQ-019 HOLD: imem_req=0. When stall=0, move the skid buffer into IF/ID, set pc <= pc+4 and go to FETCH.
REQ-020 KILL: imem_req=1 at the old latched address. On imem_rvalid=1, discard rdata and go to FETCH with pc equal to the stored target.
REQ-021 branch_taken=1 in any state SHALL override stall and flush the IF/ID slot on the same edge: if_id_valid=0 and if_id_inst=NOP_INST.
REQ-022 branch_taken=1 in any state SHALL set pc <= {branch_target[31:2],2'b00}, with bits [1:0] forced to zero.
REQ-023 Branch routing by state:
- FETCH with imem_rvalid=1: drop the response; stay in FETCH.
- FETCH with imem_rvalid=0: go to KILL.
- HOLD: drop the skid buffer; go to FETCH.
- KILL: replace the stored target; stay in KILL unless imem_rvalid=1.
REQ-024 When stall=0 and no new instruction is loaded, IF/ID SHALL empty: if_id_valid=0 and if_id_inst=NOP_INST.
REQ-025 When stall=1 and no branch is taken, if_id_valid, if_id_pc and if_id_inst SHALL hold their values.
REQ-026 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 wraps to 32'h0000_0000.
REQ-027 Fetch-to-IF/ID latency SHALL be 0 cycles after imem_rvalid: IF/ID updates on the same edge that samples imem_rvalid=1. Throughput SHALL be one instruction per cycle when imem_rvalid stays high.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL set:
- pc = RESET_PC, state = FETCH
- if_id_valid = 0, if_id_pc = 0, if_id_inst = NOP_INST
- skid buffer empty, stored target = 0
REQ-029 imem_req SHALL be 0 while rst=1 and SHALL go to 1 in the first cycle after rst deasserts.
REQ-030 Reset mid-operation, including in KILL or HOLD, SHALL abandon any outstanding response. A stale imem_rvalid in the first cycle after reset SHALL be ignored.

Verification
REQ-031 Zero-wait memory, imem_rvalid=1 every cycle, rdata = address -> IF/ID shows pc 0,4,8,12 on consecutive cycles with if_id_valid=1.
REQ-032 2-cycle memory latency -> imem_addr is stable for 2 cycles per fetch; if_id_valid pulses for 1 cycle per fetch; the pc sequence has no gaps.
REQ-033 stall=1 for 3 cycles with a response arriving -> IF/ID is frozen, state HOLD, imem_req=0; after release, the skid instruction appears next with no loss or duplication.
REQ-034 branch_taken=1, target 32'h0000_0102, during an outstanding wait -> state KILL; the old response is discarded; the next imem_addr is 32'h0000_0100; IF/ID is flushed to NOP_INST.
REQ-035 branch_taken and stall asserted together with an occupied slot -> if_id_valid=0 on the next edge; the skid buffer is dropped.
REQ-036 Reset asserted in KILL with imem_rvalid=1 in the following cycle -> the response is ignored and the first loaded if_id_pc equals RESET_PC.
